gray_ptr_sync_rx: RTL and testbench
===================================

// Module: gray_ptr_sync_rx
// PURPOSE
//  Destination-domain receiver for a Gray-coded FIFO pointer launched from a foreign clock domain.
//  Parametrised successor of the fixed 2-flop bin/gray pointer crossing:
//  - configurable synchroniser depth
//  - registered binary pointer
//  - per-cycle advance (delta) and update pulse
//  - start-up settle indicator
//  - sticky pointer-step error detector
//  Sits on both sides of the async FIFO (wr ptr into rd domain, rd ptr into wr domain).
// PARAMETERS
//  SIZE         4               pointer width incl. wrap bit (FIFO depth = 2**(SIZE-1))
//  SYNC_STAGES  2               synchroniser flop count, legal 2..4 (elaboration error otherwise)
//  MAX_STEP     2**(SIZE-1)     largest legal binary advance per dest_clk cycle
// PORTS
//  Clock and reset: one clock, dest_clk; reset rst_n is asynchronous and active-low.
//  dest_clk       in   1     destination clock, rising edge
//  rst_n          in   1     async active-low reset
//  gray_in        in   SIZE  Gray pointer from source domain (source-registered, async to dest_clk)
//  err_clr        in   1     sync clear of err_step
//  gray_sync_out  out  SIZE  last synchroniser stage, Gray
//  bin_out        out  SIZE  registered binary pointer
//  delta_out      out  SIZE  binary advance since previous cycle, mod 2**SIZE
//  upd_pulse      out  1     1-cycle pulse when synchronised pointer changed
//  settled        out  1     synchroniser flushed since reset
//  err_step       out  1     sticky: illegal pointer step seen
// BEHAVIOUR
//  - Reset:
//    - rst_n low clears all flops asynchronously: chain, g_prev, bin_out, delta_out, upd_pulse,
//      settle counter, settled, err_step.
//    - Mid-operation reset takes effect immediately with no drain.
//  - Chain: stage0 samples gray_in; stage k samples stage k-1. g_sync = stage SYNC_STAGES-1 = gray_sync_out.
//  - g_prev <= g_sync every cycle.
//  - Each cycle, with b_now = gray2bin(g_sync) and b_prev = gray2bin(g_prev):
//    - bin_out <= b_now
//    - delta_out <= (b_now - b_prev) mod 2**SIZE
//    - upd_pulse <= settled & (g_sync != g_prev)
//  - Latency: gray_in stable before edge 1 -> gray_sync_out valid after edge SYNC_STAGES;
//    bin_out / delta_out / upd_pulse after edge SYNC_STAGES+1.
//  - Settle counter: counts 0..SYNC_STAGES+1 and saturates; settled=1 at saturation.
//    Before settled: upd_pulse=0, err_step not set. delta_out and bin_out still track.
//  - Error:
//    - Set when settled & (b_now - b_prev) mod 2**SIZE > MAX_STEP (backward move or over-depth jump).
//    - Holds until err_clr. Same-cycle set and err_clr: set wins.
//  - Wrap-around: max code -> 0 is a normal +1 step; delta_out=1, no error.
//  - Multi-code advance (fast source) is legal up to MAX_STEP; no Hamming check.
//  - No combinational path from gray_in to any output.
// STRUCTURE
//  - Package fifo_sync_pkg holds:
//    - functions bin2gray(), gray2bin() (SIZE-generic via parameterised class or max-width + mask)
//    - localparams MIN_SYNC_STAGES=2, MAX_SYNC_STAGES=4
//  - Sub-module sync_flop_chain #(WIDTH, STAGES): N-flop async-reset synchroniser, one instance.
//  - Top holds the g_prev register, output registers, settle counter and error logic.
// TESTING  (SIZE=4, SYNC_STAGES=2, MAX_STEP=8 unless stated)
//  1. Reset: run at ptr 5, pull rst_n low between edges -> all outputs 0 before next edge;
//     settled re-rises on 3rd edge after release.
//  2. Latency: settled, gray_in 0000->0001 -> gray_sync_out=0001 at edge 2; at edge 3 bin_out=1,
//     delta_out=1, upd_pulse=1 for exactly one cycle.
//  3. Wrap: step gray_in through all 16 codes, one change per 4 cycles; 1000->0000 gives bin_out=0,
//     delta_out=1, err_step=0 throughout.
//  4. Fast source: gray_in 0011 (bin 2) -> 0111 (bin 5) in one step -> delta_out=3, one upd_pulse,
//     err_step=0.
//  5. Error: bin 5 -> bin 3 (gray 0010) -> delta_out=14, err_step=1 and held.
//     err_clr pulse -> 0. err_clr in same cycle as new violation -> stays 1.
//  6. Settle masking: gray_in=0110 during reset, released -> bin_out reaches 4 with upd_pulse=0 and
//     err_step=0 until settled; SYNC_STAGES=4 build: settled on 5th edge.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for Gray-coded FIFO pointer crossings: code conversions and
// synchroniser depth limits used by the pointer receivers.
package fifo_sync_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MAX_PTR_W       = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Pointers narrower than MAX_PTR_W ride in the low bits; the mask keeps
    // stray upper bits from leaking into the conversion.
    function automatic ptr_t width_mask(input int unsigned w);
        ptr_t m;
        if (w >= MAX_PTR_W) begin
            m = '1;
        end else begin
            m = (ptr_t'(1) << w) - ptr_t'(1);
        end
        return m;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int unsigned w);
        ptr_t bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g, input int unsigned w);
        ptr_t gm;
        ptr_t b;
        gm = g & width_mask(w);
        b  = gm;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_flop_chain.sv
// Multi-flop synchroniser for a bus whose value changes one bit at a time
// (Gray code), reset asynchronously to all-zero.
module sync_flop_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // NOTE: every flop here holds state, so it is written with <= ; a blocking
    // assignment would let a value ripple through several stages in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_rx.sv
// Destination-side receiver for a Gray FIFO pointer: synchronises it, converts
// to binary, reports per-cycle advance, and flags illegal pointer steps.
module gray_ptr_sync_rx
    import fifo_sync_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 2 ** (SIZE - 1)
) (
    input  logic            dest_clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] gray_in,
    input  logic            err_clr,
    output logic [SIZE-1:0] gray_sync_out,
    output logic [SIZE-1:0] bin_out,
    output logic [SIZE-1:0] delta_out,
    output logic            upd_pulse,
    output logic            settled,
    output logic            err_step
);

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync_stages
        $error("gray_ptr_sync_rx: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (SIZE < 2 || SIZE > MAX_PTR_W) begin : g_bad_size
        $error("gray_ptr_sync_rx: SIZE=%0d outside 2..%0d", SIZE, MAX_PTR_W);
    end

    // The settle counter runs until the chain and g_prev both hold post-reset data.
    localparam int              SETTLE_MAX  = SYNC_STAGES + 1;
    localparam int              CNT_W       = $clog2(SETTLE_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_MAX - 1);
    localparam logic [SIZE:0]    MAX_STEP_C  = (SIZE + 1)'(MAX_STEP);

    logic [SIZE-1:0]  w_g_sync;
    logic [SIZE-1:0]  w_b_now;
    logic [SIZE-1:0]  w_b_prev;
    logic [SIZE-1:0]  w_step;
    logic             w_step_bad;

    logic [SIZE-1:0]  r_g_prev;
    logic [SIZE-1:0]  r_bin;
    logic [SIZE-1:0]  r_delta;
    logic             r_upd;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_settled;
    logic             r_err;

    sync_flop_chain #(
        .WIDTH  (SIZE),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .clk   (dest_clk),
        .rst_n (rst_n),
        .i_d   (gray_in),
        .o_q   (w_g_sync)
    );

    assign w_b_now    = SIZE'(gray2bin(ptr_t'(w_g_sync), SIZE));
    assign w_b_prev   = SIZE'(gray2bin(ptr_t'(r_g_prev), SIZE));
    assign w_step     = w_b_now - w_b_prev;
    // A backward move wraps to a large modular step, so one compare catches both cases.
    assign w_step_bad = {1'b0, w_step} > MAX_STEP_C;

    always_ff @(posedge dest_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g_prev     <= '0;
            r_bin        <= '0;
            r_delta      <= '0;
            r_upd        <= 1'b0;
            r_settle_cnt <= '0;
            r_settled    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_g_prev <= w_g_sync;
            r_bin    <= w_b_now;
            r_delta  <= w_step;
            r_upd    <= r_settled & (w_g_sync != r_g_prev);

            if (!r_settled) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
                r_settled    <= (r_settle_cnt == SETTLE_LAST);
            end

            // A new violation outranks a clear arriving on the same edge.
            r_err <= (r_settled & w_step_bad) | (r_err & ~err_clr);
        end
    end

    assign gray_sync_out = w_g_sync;
    assign bin_out       = r_bin;
    assign delta_out     = r_delta;
    assign upd_pulse     = r_upd;
    assign settled       = r_settled;
    assign err_step      = r_err;

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Self-checking bench: two receivers (2 and 4 sync stages) fed by one binary
// pointer, compared each cycle against a delay-line model of that pointer.
module tb_gray_ptr_sync_rx;

    logic       dest_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       err_clr  = 1'b0;
    logic [3:0] ptr      = 4'd0;
    logic [3:0] gray_in;

    logic [3:0] gso2, bin2, dlt2, gso4, bin4, dlt4;
    logic       upd2, stl2, err2, upd4, stl4, err4;
    logic [14:0] obs2, obs4;

    int n_cmp = 0;
    int n_bad = 0;

    assign gray_in = ptr ^ (ptr >> 1);
    assign obs2    = {gso2, bin2, dlt2, upd2, stl2, err2};
    assign obs4    = {gso4, bin4, dlt4, upd4, stl4, err4};

    always #5 dest_clk = ~dest_clk;

    gray_ptr_sync_rx #(.SIZE(4), .SYNC_STAGES(2), .MAX_STEP(8)) u_dut2 (
        .dest_clk (dest_clk), .rst_n (rst_n), .gray_in (gray_in), .err_clr (err_clr),
        .gray_sync_out (gso2), .bin_out (bin2), .delta_out (dlt2),
        .upd_pulse (upd2), .settled (stl2), .err_step (err2)
    );

    gray_ptr_sync_rx #(.SIZE(4), .SYNC_STAGES(4), .MAX_STEP(8)) u_dut4 (
        .dest_clk (dest_clk), .rst_n (rst_n), .gray_in (gray_in), .err_clr (err_clr),
        .gray_sync_out (gso4), .bin_out (bin4), .delta_out (dlt4),
        .upd_pulse (upd4), .settled (stl4), .err_step (err4)
    );

    // Reference model: hist[k] is the binary pointer sampled k edges ago
    // (zero-filled by reset); m_edges counts edges since reset release.
    logic [3:0] hist [0:7];
    int         m_edges;
    logic       m_err2, m_err4;

    always @(posedge dest_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= 4'd0;
            m_edges <= 0;
            m_err2  <= 1'b0;
            m_err4  <= 1'b0;
        end else begin
            for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= ptr;
            if (m_edges < 1000) m_edges <= m_edges + 1;
            if (m_edges >= 3 && 4'(hist[1] - hist[2]) > 4'd8) m_err2 <= 1'b1;
            else if (err_clr) m_err2 <= 1'b0;
            if (m_edges >= 5 && 4'(hist[3] - hist[4]) > 4'd8) m_err4 <= 1'b1;
            else if (err_clr) m_err4 <= 1'b0;
        end
    end

    function automatic logic [14:0] exp_vec(input int s);
        logic [3:0] b, bp, d;
        logic       upd, stl, er;
        b   = hist[s];
        bp  = hist[s+1];
        d   = b - bp;
        stl = (m_edges >= s + 1);
        upd = (m_edges >= s + 2) && (b != bp);
        er  = (s == 2) ? m_err2 : m_err4;
        return {hist[s-1] ^ (hist[s-1] >> 1), b, d, upd, stl, er};
    endfunction

    task automatic tick();
        @(posedge dest_clk);
        @(negedge dest_clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ptr = 4'd5; err_clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL reset_run_s2 c=%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL reset_run_s4 c=%0d got=%h exp=%h", c, obs4, exp_vec(4)); end
        end
        n_cmp++; if (bin2 !== 4'd5) begin n_bad++; $display("FAIL reset_pre_bin got=%0d exp=5", bin2); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (obs2 !== 15'd0) begin n_bad++; $display("FAIL reset_async_s2 got=%h exp=0", obs2); end
        n_cmp++; if (obs4 !== 15'd0) begin n_bad++; $display("FAIL reset_async_s4 got=%h exp=0", obs4); end
        @(negedge dest_clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_cmp++; if (stl2 !== (e >= 3)) begin n_bad++; $display("FAIL reset_settle_s2 edge=%0d got=%b exp=%b", e, stl2, e >= 3); end
            n_cmp++; if (stl4 !== (e >= 5)) begin n_bad++; $display("FAIL reset_settle_s4 edge=%0d got=%b exp=%b", e, stl4, e >= 5); end
        end
    endtask

    task automatic test_latency();
        ptr = 4'd0;
        repeat (6) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tick();
        ptr = 4'd1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL latency_s2 edge=%0d got=%h exp=%h", e, obs2, exp_vec(2)); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL latency_s4 edge=%0d got=%h exp=%h", e, obs4, exp_vec(4)); end
            if (e == 1) begin
                n_cmp++; if (gso2 !== 4'b0000) begin n_bad++; $display("FAIL latency_gsync_e1 got=%b exp=0000", gso2); end
            end
            if (e == 2) begin
                n_cmp++; if ({gso2, upd2} !== {4'b0001, 1'b0}) begin n_bad++; $display("FAIL latency_gsync_e2 got=%b/%b exp=0001/0", gso2, upd2); end
            end
            if (e == 3) begin
                n_cmp++; if ({bin2, dlt2, upd2} !== {4'd1, 4'd1, 1'b1}) begin n_bad++; $display("FAIL latency_bin_e3 got=%0d/%0d/%b exp=1/1/1", bin2, dlt2, upd2); end
            end
            if (e == 4) begin
                n_cmp++; if (upd2 !== 1'b0) begin n_bad++; $display("FAIL latency_pulse_e4 got=%b exp=0", upd2); end
            end
        end
    endtask

    task automatic test_wrap();
        bit wrap_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ptr = ptr + 4'd1;
            for (int c = 0; c < 4; c++) begin
                tick();
                n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL wrap_s2 k=%0d got=%h exp=%h", k, obs2, exp_vec(2)); end
                n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL wrap_s4 k=%0d got=%h exp=%h", k, obs4, exp_vec(4)); end
                n_cmp++; if ({err2, err4} !== 2'b00) begin n_bad++; $display("FAIL wrap_err k=%0d got=%b%b exp=00", k, err2, err4); end
                if (upd2 === 1'b1 && bin2 === 4'd0) begin
                    wrap_seen = 1'b1;
                    n_cmp++; if (dlt2 !== 4'd1) begin n_bad++; $display("FAIL wrap_delta got=%0d exp=1", dlt2); end
                end
            end
        end
        n_cmp++; if (wrap_seen !== 1'b1) begin n_bad++; $display("FAIL wrap_seen got=%b exp=1", wrap_seen); end
    endtask

    task automatic test_fast_source();
        int pulses = 0;
        ptr = 4'd2;
        repeat (6) tick();
        ptr = 4'd5;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL fast_s2 c=%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL fast_s4 c=%0d got=%h exp=%h", c, obs4, exp_vec(4)); end
            if (upd2 === 1'b1) begin
                pulses++;
                n_cmp++; if (dlt2 !== 4'd3) begin n_bad++; $display("FAIL fast_delta got=%0d exp=3", dlt2); end
            end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL fast_pulses got=%0d exp=1", pulses); end
        n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL fast_err got=%b exp=0", err2); end
    endtask

    task automatic test_error();
        ptr = 4'd3;
        repeat (3) tick();
        n_cmp++; if ({dlt2, err2} !== {4'd14, 1'b1}) begin n_bad++; $display("FAIL err_set got=%0d/%b exp=14/1", dlt2, err2); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL err_hold c=%0d got=%b exp=1", c, err2); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL err_hold_s4 c=%0d got=%h exp=%h", c, obs4, exp_vec(4)); end
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", err2); end
        n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL err_clear_s4 got=%h exp=%h", obs4, exp_vec(4)); end
        ptr = 4'd1;
        repeat (2) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++; if ({dlt2, err2} !== {4'd14, 1'b1}) begin n_bad++; $display("FAIL err_set_wins got=%0d/%b exp=14/1", dlt2, err2); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL err_tail_s2 c=%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL err_tail_s4 c=%0d got=%h exp=%h", c, obs4, exp_vec(4)); end
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_settle_mask();
        rst_n = 1'b0; ptr = 4'd4;
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++; if ({upd2, err2, upd4, err4} !== 4'b0000) begin n_bad++; $display("FAIL mask_flags edge=%0d got=%b%b%b%b exp=0000", e, upd2, err2, upd4, err4); end
            n_cmp++; if (bin2 !== ((e >= 3) ? 4'd4 : 4'd0)) begin n_bad++; $display("FAIL mask_bin_s2 edge=%0d got=%0d", e, bin2); end
            n_cmp++; if (stl4 !== (e >= 5)) begin n_bad++; $display("FAIL mask_settle_s4 edge=%0d got=%b exp=%b", e, stl4, e >= 5); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL mask_s4 edge=%0d got=%h exp=%h", e, obs4, exp_vec(4)); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)       ptr = ptr + 4'($urandom_range(1, 8));
            else if (r == 3) ptr = 4'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            if (c == 300) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++; if (obs2 !== 15'd0) begin n_bad++; $display("FAIL rand_reset got=%h exp=0", obs2); end
                @(negedge dest_clk);
                rst_n = 1'b1;
            end
            tick();
            n_cmp++; if (obs2 !== exp_vec(2)) begin n_bad++; $display("FAIL rand_s2 c=%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
            n_cmp++; if (obs4 !== exp_vec(4)) begin n_bad++; $display("FAIL rand_s4 c=%0d got=%h exp=%h", c, obs4, exp_vec(4)); end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_fast_source();
        test_error();
        test_settle_mask();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
